// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with level/threshold flags and overflow pulse.
// Optional saturating drop counter enabled by defining STREAM_FIFO_DROP_COUNT_EN.
module stream_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   write_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   full,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow
`ifdef STREAM_FIFO_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  // The head entry lives in a register stage; the array holds everything behind it.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q;

  logic pop, accept, reject, ram_empty, ram_we;

  always_comb begin
    pop       = head_vld_q && out_ready;
    ram_empty = (wr_ptr_q == rd_ptr_q);
    accept    = write_en && !clear && ((level_q != DEPTH_L) || pop);
    reject    = write_en && !clear && (level_q == DEPTH_L) && !pop;
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ram_we     = 1'b0;
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      head_vld_d = 1'b0;
    end else begin
      if (!head_vld_q || pop) begin
        if (!ram_empty) begin
          head_d     = mem[rd_ptr_q[AW-1:0]];
          head_vld_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + LW'(1);
          ram_we     = accept;
        end else if (accept) begin
          head_d     = data_in;
          head_vld_d = 1'b1;
        end else begin
          head_vld_d = 1'b0;
        end
      end else begin
        ram_we = accept;
      end
      if (ram_we) begin
        wr_ptr_d = wr_ptr_q + LW'(1);
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      full_q     <= (level_d == DEPTH_L);
      empty_q    <= (level_d == '0);
      af_q       <= (level_d >= AF_L);
      ae_q       <= (level_d <= AE_L);
      ovf_q      <= reject;
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

`ifdef STREAM_FIFO_DROP_COUNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (clear) begin
      drop_q <= '0;
    end else if (reject && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign level        = level_q;
  assign out_valid    = head_vld_q;
  assign out_data     = head_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (WIDTH=8, DEPTH=16) with a queue-based scoreboard.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       write_en;
  logic [7:0] data_in;
  logic       full;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
`ifdef STREAM_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  stream_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .write_en     (write_en),
    .data_in      (data_in),
    .full         (full),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
`ifdef STREAM_FIFO_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  int         exp_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
    chk({tag, ".level"}, 32'(level), 32'(sz));
    chk({tag, ".full"}, 32'(full), 32'(sz == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= 14));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 1));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    if (sz > 0) chk({tag, ".head"}, 32'(out_data), 32'(q[0]));
`ifdef STREAM_FIFO_DROP_COUNT_EN
    chk({tag, ".drop_count"}, 32'(drop_count), 32'(exp_drop));
`endif
  endtask

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic step(input string tag, input logic we, input logic [7:0] d,
                      input logic rdy, input logic clr);
    int   sz;
    logic pop, acc, rej;
    write_en  = we;
    data_in   = d;
    out_ready = rdy;
    clear     = clr;
    sz  = q.size();
    pop = (sz > 0) && rdy;
    acc = we && !clr && ((sz < 16) || pop);
    rej = we && !clr && (sz == 16) && !pop;
    if (clr) begin
      q.delete();
      exp_ovf  = 1'b0;
      exp_drop = 0;
    end else begin
      if (pop) chk({tag, ".pop_data"}, 32'(out_data), 32'(q.pop_front()));
      if (acc) q.push_back(d);
      exp_ovf = rej;
      if (rej && exp_drop < 65535) exp_drop++;
    end
    @(posedge clk);
    #1;
    check_state(tag);
    @(negedge clk);
    write_en  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    reset_n   = 1'b0;
    clear     = 1'b0;
    write_en  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset.out_data", 32'(out_data), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single write then pop
    step("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("pop_a5", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, overflow pulse, drain in order
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 8'hEE, 1'b0, 1'b0);
    step("ovf_gone", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Pass-through while full, then continuous write+pop across pointer wrap
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step("pass_55", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure holds the head stable, a single ready advances once
    for (int i = 0; i < 3; i++) step("bp_fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    held = q[0];
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("bp_hold.stable", 32'(out_data), 32'(held));
    end
    step("bp_adv", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear wins over a simultaneous write; out_data keeps its last value
    for (int i = 0; i < 7; i++) step("cl_fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    held = q[0];
    step("clear", 1'b1, 8'h99, 1'b1, 1'b1);
    chk("clear.out_data_kept", 32'(out_data), 32'(held));
    step("wr_3c", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("pop_3c", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 5; i++) step("ar_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    write_en  = 1'b1;
    data_in   = 8'h77;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    q.delete();
    exp_ovf  = 1'b0;
    exp_drop = 0;
    #1;
    check_state("async_rst");
    write_en  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step("ar_wr", 1'b1, 8'h6B, 1'b0, 1'b0);
    step("ar_wr2", 1'b1, 8'h6C, 1'b0, 1'b0);
    step("ar_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    step("ar_pop2", 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef STREAM_FIFO_DROP_COUNT_EN
    for (int i = 0; i < 16; i++) step("dc_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("dc_drop", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("dc_three", 32'(drop_count), 32'd3);
    for (int i = 0; i < 70000; i++) step("dc_sat", 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("dc_saturated", 32'(drop_count), 32'hFFFF);
    step("dc_clear", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("dc_cleared", 32'(drop_count), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Single-clock, parametrised FIFO. Generalises the fixed 4-entry, fixed-width FIFO to configurable width and depth. Adds first-word-fall-through valid/ready read handshake, level and threshold flags, overflow reporting, and synchronous flush. Sits between bridge/APF command decoders and core-side consumers that need buffering without a clock crossing.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, capacity in entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  sole clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush
write_en  in  1  write request
data_in  in  WIDTH  write data
full  out  1  level == DEPTH
out_valid  out  1  head entry presented on out_data
out_ready  in  1  consumer accepts head
out_data  out  WIDTH  head entry (first-word-fall-through)
level  out  $clog2(DEPTH)+1  entries held
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
overflow  out  1  one-cycle pulse, write dropped

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values: out_valid 0, out_data 0, level 0, full 0, empty 1, almost_full 0, almost_empty 1, overflow 0. Pointers zero.
- Read handshake: pop when out_valid && out_ready. out_valid deasserts only by pop or clear. out_data is stable while out_valid && !out_ready.
- Write: accepted when write_en && (level < DEPTH || pop in same cycle). Pass-through when full: accept/pop combine, level unchanged.
- Rejected write (write_en, level == DEPTH, no pop): data dropped, contents unchanged, overflow = 1 on next cycle for exactly one cycle.
- Latency: write accepted at edge N into an empty FIFO gives out_valid = 1 with that data after edge N (visible cycle N+1). No write-to-read bypass in the same cycle.
- Level: +1 on accept-only, -1 on pop-only, unchanged on both or neither. Registered, updates at the same edge as the event. Never exceeds DEPTH and never underflows.
- All flags (full, empty, almost_*) are registered and derived from the next level. They are consistent with level in every cycle.
- Ordering: strict FIFO. Pointer wrap-around at DEPTH is transparent to data order (extra pointer MSB for full/empty).
- clear: level→0, out_valid→0, empty→1, almost_empty→1, full/almost_full→0. Takes priority over a same-cycle write and pop; the write is discarded without an overflow pulse. out_data retains its last value.
- Async reset mid-transfer: all state returns to reset values immediately; the next accepted write is the new head.
- Storage: inferable RAM or register array. out_data is registered.

Optional Feature:
Macro STREAM_FIFO_DROP_COUNT_EN.
- Defined: adds output drop_count (16 bits). Increments on every rejected write and saturates at 16'hFFFF. Cleared by reset_n and clear.
- Undefined: port absent; overflow pulse only.

Test Plan:
- Reset then write 0xA5 (WIDTH=8) → next cycle out_valid=1, out_data=0xA5, level=1, empty=0, almost_empty=1.
- Write 16 entries 0x00..0x0F with out_ready=0 → full=1, level=16, almost_full=1 from level 14. A 17th write of 0xEE gives a 1-cycle overflow pulse. Draining yields exactly 0x00..0x0F in order.
- When full, write 0x55 while popping → no overflow, level stays 16; 0x55 emerges 16 pops later. Continuous write+pop for 40 cycles checks wrap-around ordering.
- Hold out_ready=0 with out_valid=1 for 5 cycles → out_data constant; one cycle with out_ready=1 advances the head once.
- Fill 7 entries, then assert clear with a simultaneous write → next cycle level=0, out_valid=0, empty=1, overflow=0. A subsequent write of 0x3C becomes the head.
- With STREAM_FIFO_DROP_COUNT_EN: 3 rejected writes → drop_count=3. Force 70000 drops → drop_count holds 0xFFFF. clear → 0.
